// File: rtl/aes_round_ctrl.sv
// AES-128 encryption sequencer: key-expansion handshake, then rounds 0..10 on the round datapath.
// Optional key cache enabled by defining AES_KEY_CACHE_EN (default build has no cache).
module aes_round_ctrl #(
   parameter int KEYGEN_TIMEOUT = 31,
   parameter int NUM_ROUNDS     = 10
) (
   input  logic         pi_clk,
   input  logic         pi_rst,
   input  logic         pi_start,
   input  logic         pi_abort,
   input  logic [127:0] pi_key,
   input  logic         pi_keys_generated,
   output logic         po_ready,
   output logic         po_busy,
   output logic [127:0] po_key_out,
   output logic         po_generate_keys,
   output logic [3:0]   po_current_round,
   output logic         po_load_state,
   output logic         po_round_en,
   output logic         po_last_round,
   output logic         po_done,
   output logic         po_error
);

   typedef enum logic [2:0] {
      S_IDLE, S_KEY_REQ, S_KEY_WAIT, S_LOAD, S_ROUND, S_FINAL, S_DONE
   } state_t;

   localparam logic [7:0] TMO_LAST   = 8'(KEYGEN_TIMEOUT - 1);
   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

   state_t       r_state;
   state_t       w_next;
   logic [127:0] r_key;
   logic [7:0]   r_tmo_cnt;
   logic [3:0]   r_round;
   logic         r_error;
   logic         w_accept;
   logic         w_timeout;
   logic         w_cache_hit;

   assign w_accept  = (r_state == S_IDLE) && pi_start && !pi_abort;
   assign w_timeout = (r_state == S_KEY_WAIT) && !pi_keys_generated && (r_tmo_cnt == TMO_LAST);

`ifdef AES_KEY_CACHE_EN
   logic r_key_valid;

   // Round keys stay valid until a key expansion is abandoned (abort or timeout).
   always_ff @(posedge pi_clk) begin
      if (pi_rst)
         r_key_valid <= 1'b0;
      else if (pi_abort && (r_state == S_KEY_REQ || r_state == S_KEY_WAIT))
         r_key_valid <= 1'b0;
      else if (w_timeout)
         r_key_valid <= 1'b0;
      else if (r_state == S_KEY_WAIT && pi_keys_generated)
         r_key_valid <= 1'b1;
   end

   assign w_cache_hit = r_key_valid && (pi_key == r_key);
`else
   assign w_cache_hit = 1'b0;
`endif

   always_ff @(posedge pi_clk) begin
      if (pi_rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (pi_abort) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:     if (w_accept) w_next = w_cache_hit ? S_LOAD : S_KEY_REQ;
            S_KEY_REQ:  w_next = S_KEY_WAIT;
            S_KEY_WAIT: begin
               if (pi_keys_generated)
                  w_next = S_LOAD;
               else if (w_timeout)
                  w_next = S_IDLE;
            end
            S_LOAD:     w_next = S_ROUND;
            S_ROUND:    if (r_round == LAST_ROUND - 4'd1) w_next = S_FINAL;
            S_FINAL:    w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
         endcase
      end
   end

   // Error is registered so it appears as a one-cycle pulse in the IDLE cycle after the timeout.
   always_ff @(posedge pi_clk) begin
      if (pi_rst) begin
         r_key     <= '0;
         r_tmo_cnt <= '0;
         r_round   <= '0;
         r_error   <= 1'b0;
      end else begin
         r_error <= w_timeout && !pi_abort;
         if (w_accept)
            r_key <= pi_key;
         if (r_state == S_KEY_REQ)
            r_tmo_cnt <= '0;
         else if (r_state == S_KEY_WAIT)
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
         if (r_state == S_LOAD)
            r_round <= 4'd1;
         else if (r_state == S_ROUND)
            r_round <= r_round + 4'd1;
      end
   end

   assign po_key_out = r_key;

   always_comb begin
      po_ready         = 1'b0;
      po_busy          = 1'b1;
      po_generate_keys = 1'b0;
      po_current_round = 4'd0;
      po_load_state    = 1'b0;
      po_round_en      = 1'b0;
      po_last_round    = 1'b0;
      po_done          = 1'b0;
      po_error         = r_error;
      case (r_state)
         S_IDLE: begin
            po_ready = 1'b1;
            po_busy  = 1'b0;
         end
         S_KEY_REQ: po_generate_keys = 1'b1;
         S_LOAD:    po_load_state    = 1'b1;
         S_ROUND: begin
            po_current_round = r_round;
            po_round_en      = 1'b1;
         end
         S_FINAL: begin
            po_current_round = LAST_ROUND;
            po_round_en      = 1'b1;
            po_last_round    = 1'b1;
         end
         S_DONE: begin
            po_current_round = LAST_ROUND;
            po_done          = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Sequences one AES-128 encryption: requests round-key expansion, waits for the keys-ready pulse, then steps the round datapath through rounds 0..10.
- Drives the round-key selector (round index) and the round-datapath strobes.
- Sits between the top-level start/done interface and the key-expansion and round-datapath blocks.

Parameters:
KEYGEN_TIMEOUT, 31, max cycles in KEY_WAIT without pi_keys_generated before error (1..255)
NUM_ROUNDS, 10, last round index (fixed 10 for AES-128; other values unsupported)

Ports:
pi_clk  in  1  clock, rising edge
pi_rst  in  1  synchronous reset, active-high
pi_start  in  1  start request, accepted only when po_ready=1
pi_abort  in  1  abort current operation, any state
pi_key  in  128  cipher key, sampled on start acceptance
pi_keys_generated  in  1  one-cycle pulse from key expansion: all round keys valid
po_ready  out  1  high in IDLE
po_busy  out  1  high in every state except IDLE
po_key_out  out  128  latched key to key-expansion input
po_generate_keys  out  1  one-cycle key-expansion request
po_current_round  out  4  round index to key selector and datapath
po_load_state  out  1  round 0: load plaintext and apply initial AddRoundKey
po_round_en  out  1  rounds 1..10: datapath performs one round
po_last_round  out  1  round 10: datapath skips MixColumns
po_done  out  1  one-cycle pulse: ciphertext valid
po_error  out  1  one-cycle pulse: key-generation timeout

Behaviour:
- Reset, synchronous, highest priority: state=IDLE; po_key_out=0; round=0; timeout counter=0.
- All outputs in reset: po_ready=1, every other output 0.
- States: IDLE, KEY_REQ, KEY_WAIT, LOAD, ROUND, FINAL, DONE. All outputs are decoded from registered state.
- IDLE: po_current_round=0. If pi_start=1 and pi_abort=0, latch pi_key into po_key_out and go to KEY_REQ (or LOAD on cache hit, see Optional Feature).
- KEY_REQ: po_generate_keys=1 for exactly one cycle; clear timeout counter; go to KEY_WAIT.
- KEY_WAIT: count cycles.
  - pi_keys_generated=1 -> LOAD.
  - Counter reaches KEYGEN_TIMEOUT without the pulse -> po_error=1 for one cycle, go to IDLE.
  - A pi_keys_generated pulse outside KEY_WAIT is ignored.
- LOAD: po_current_round=0, po_load_state=1; set round=1; go to ROUND.
- ROUND: po_current_round=round (1..9), po_round_en=1; round increments each cycle; when round=9, go to FINAL.
- FINAL: po_current_round=10, po_round_en=1, po_last_round=1; go to DONE.
- DONE: po_done=1, po_current_round holds 10; go to IDLE.
- Latency, start accepted at cycle 0 with pulse seen in cycle W: LOAD at W+1, rounds 1..9 at W+2..W+10, FINAL at W+11, po_done at W+12.
- po_key_out is stable from acceptance until the next accepted start. It is never changed mid-operation.
- pi_start while busy: ignored, not queued.
- pi_abort=1 in any non-IDLE state:
  - next state is IDLE; no po_done and no po_error.
  - all strobes are low in the following cycle.
  - abort in KEY_REQ/KEY_WAIT invalidates the cache.
- pi_abort and pi_start together in IDLE: start is ignored.
- Reset mid-operation: same as the reset values above; the cache is invalidated.

Optional Feature:
- Macro: AES_KEY_CACHE_EN.
- Defined:
  - Hold a key_valid flag. It is set on entering LOAD from KEY_WAIT.
  - It is cleared by reset, abort during key generation, or timeout.
  - On start with key_valid=1 and pi_key==po_key_out: IDLE -> LOAD directly, skipping KEY_REQ/KEY_WAIT. Latency to po_done is 12 cycles.
  - On a different key: normal expansion path, and po_key_out is updated.
- Undefined: every start goes through KEY_REQ/KEY_WAIT; no comparator and no flag.

Test Plan:
1. Reset, then start with key 2b7e151628aed2a6abf7158809cf4f3c; keys pulse 13 cycles after po_generate_keys -> one po_generate_keys pulse; rounds 0,1..9,10 on consecutive cycles; po_last_round only at 10; po_done exactly 12 cycles after the keys pulse.
2. No keys pulse after start -> po_error pulse after KEYGEN_TIMEOUT=31 wait cycles; back to IDLE with po_ready=1; no po_done.
3. pi_abort at round 5 -> IDLE next cycle; po_round_en=0; no po_done; a new start succeeds normally.
4. pi_start held high during the whole operation -> exactly one po_done; second start accepted only on the cycle after DONE returns to IDLE.
5. Simultaneous pi_start and pi_abort in IDLE -> remains IDLE; no po_generate_keys.
6. With AES_KEY_CACHE_EN, two back-to-back starts with the same key:
   - second start: no po_generate_keys; po_done 12 cycles after acceptance.
   - third start with key 000102030405060708090a0b0c0d0e0f: po_generate_keys asserted again.
